// File: rtl/mandel_cmd_rx.sv
// mandel_cmd_rx: UART command-frame receiver for the Mandelbrot engine.
// Hunts for sync 0xA5, stages a 13-byte payload, checks an XOR checksum
// and commits the parameter set with a one-cycle start pulse.
//
// Ports:
//   clk, rst        engine clock, synchronous active-high reset
//   rx_data         byte from the UART receiver, stable while rx_ready high
//   rx_ready        asynchronous level, high while a byte is available
//   engine_busy     engine is rendering; commit waits for it to drop
//   pix_x, pix_y    last column / row index
//   cxs, cys        start coordinates (Q4.12)
//   dcx, dcy        per-pixel step (Q4.12)
//   max_iter        iteration limit
//   start           one-cycle pulse, parameters valid in the same cycle
//   err_*           one-cycle error pulses (checksum, timeout,
//                   zero max_iter, byte received while pending)
`timescale 1ns/1ps

module mandel_cmd_rx #(
    parameter int TIMEOUT_CYCLES = 700000,
    parameter int N_BIT          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             engine_busy,
    output logic [8:0]       pix_x,
    output logic [7:0]       pix_y,
    output logic [N_BIT-1:0] cxs,
    output logic [N_BIT-1:0] cys,
    output logic [N_BIT-1:0] dcx,
    output logic [N_BIT-1:0] dcy,
    output logic [15:0]      max_iter,
    output logic             start,
    output logic             err_cksum,
    output logic             err_timeout,
    output logic             err_param,
    output logic             err_overrun
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    SYNC     = 8'hA5;
    localparam logic [3:0]    IDX_LAST = 4'd12;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK_WAIT,
        PEND
    } state_t;

    state_t state;

    // rx_ready crossing: two synchronizer flops, then a registered
    // rising-edge detect so a held level yields exactly one byte.
    logic rdy_s1;
    logic rdy_s2;
    logic rdy_prev;
    logic acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_s1   <= 1'b0;
            rdy_s2   <= 1'b0;
            rdy_prev <= 1'b0;
            acc      <= 1'b0;
        end else begin
            rdy_s1   <= rx_ready;
            rdy_s2   <= rdy_s1;
            rdy_prev <= rdy_s2;
            acc      <= rdy_s2 & ~rdy_prev;
        end
    end

    // Staging: only bit 0 of payload byte 0 carries information
    // (pix_x[8]); bytes 1..12 are kept whole.
    logic            stg_px8;
    logic [7:0]      stg [1:12];
    logic [3:0]      idx;
    logic [7:0]      xacc;

    // Cycles elapsed since the last accepted byte, the accept cycle
    // itself being cycle 0. Reloading with 1 lets the registered
    // timeout pulse land exactly TIMEOUT_CYCLES after the accept.
    logic [CW-1:0]   cnt;

    logic [15:0]     stg_iter;
    logic            in_frame;
    logic            to_fire;
    logic            cks_ok;
    logic            iter_ok;
    logic            commit;

    assign stg_iter = {stg[11], stg[12]};

    always_comb begin
        in_frame = (state == PAYLOAD) || (state == CHECK_WAIT);
        // An accepted byte beats a timeout in the same cycle.
        to_fire  = in_frame && !acc && (cnt == CNT_LAST);
        cks_ok   = (rx_data == xacc);
        iter_ok  = (stg_iter != 16'd0);
        commit   = 1'b0;
        if (!engine_busy) begin
            unique case (1'b1)
                (state == PEND):       commit = 1'b1;
                (state == CHECK_WAIT): commit = acc && cks_ok && iter_ok;
                default:               commit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            idx         <= 4'd0;
            xacc        <= 8'd0;
            cnt         <= '0;
            stg_px8     <= 1'b0;
            for (int i = 1; i <= 12; i++) begin
                stg[i] <= 8'd0;
            end
            pix_x       <= 9'd510;
            pix_y       <= 8'd255;
            cxs         <= '0;
            cys         <= '0;
            dcx         <= '0;
            dcy         <= '0;
            max_iter    <= 16'd100;
            start       <= 1'b0;
            err_cksum   <= 1'b0;
            err_timeout <= 1'b0;
            err_param   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            start       <= commit;
            err_cksum   <= 1'b0;
            err_param   <= 1'b0;
            err_timeout <= to_fire;
            // Bytes during PEND are dropped, even in the commit cycle.
            err_overrun <= (state == PEND) && acc;

            if (commit) begin
                pix_x    <= {stg_px8, stg[1]};
                pix_y    <= stg[2];
                cxs      <= N_BIT'({stg[3], stg[4]});
                cys      <= N_BIT'({stg[5], stg[6]});
                dcx      <= N_BIT'({stg[7], stg[8]});
                dcy      <= N_BIT'({stg[9], stg[10]});
                max_iter <= stg_iter;
            end

            if (to_fire) begin
                state   <= HUNT;
                cnt     <= '0;
                stg_px8 <= 1'b0;
                for (int i = 1; i <= 12; i++) begin
                    stg[i] <= 8'd0;
                end
            end else begin
                unique case (state)
                    HUNT: begin
                        if (acc && rx_data == SYNC) begin
                            idx   <= 4'd0;
                            xacc  <= 8'd0;
                            cnt   <= CNT_ONE;
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        // 0xA5 here is plain data; no resync.
                        if (acc) begin
                            if (idx == 4'd0) begin
                                stg_px8 <= rx_data[0];
                            end
                            for (int i = 1; i <= 12; i++) begin
                                if (idx == 4'(i)) begin
                                    stg[i] <= rx_data;
                                end
                            end
                            xacc <= xacc ^ rx_data;
                            idx  <= idx + 4'd1;
                            cnt  <= CNT_ONE;
                            if (idx == IDX_LAST) begin
                                state <= CHECK_WAIT;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    CHECK_WAIT: begin
                        if (acc) begin
                            cnt <= '0;
                            if (!cks_ok) begin
                                err_cksum <= 1'b1;
                                state     <= HUNT;
                            end else if (!iter_ok) begin
                                err_param <= 1'b1;
                                state     <= HUNT;
                            end else if (commit) begin
                                state <= HUNT;
                            end else begin
                                state <= PEND;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PEND: begin
                        if (commit) begin
                            state <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mandel_cmd_rx.sv
// tb_mandel_cmd_rx: frame table plus hand-written corner sequences;
// expected pulses are queued when stimulus is driven.
`timescale 1ns/1ps

module tb_mandel_cmd_rx;

    localparam int TO   = 100;
    localparam int K_ST = 0;
    localparam int K_CK = 1;
    localparam int K_TO = 2;
    localparam int K_PA = 3;
    localparam int K_OV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        engine_busy;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] cxs, cys, dcx, dcy, max_iter;
    logic        start, err_cksum, err_timeout, err_param, err_overrun;

    always #5 clk = ~clk;

    mandel_cmd_rx #(
        .TIMEOUT_CYCLES (TO),
        .N_BIT          (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .engine_busy (engine_busy),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .cxs         (cxs),
        .cys         (cys),
        .dcx         (dcx),
        .dcy         (dcy),
        .max_iter    (max_iter),
        .start       (start),
        .err_cksum   (err_cksum),
        .err_timeout (err_timeout),
        .err_param   (err_param),
        .err_overrun (err_overrun)
    );

    typedef logic [7:0] pl_t [13];

    typedef struct {
        string      name;
        pl_t        pl;
        logic [7:0] mask;
        int         kind;
    } vec_t;

    typedef struct {
        int          kind;
        int          cyc;
        logic [8:0]  px;
        logic [7:0]  py;
        logic [15:0] cx, cy, dx, dy, mi;
    } ev_t;

    string kname [5] = '{"start", "err_cksum", "err_timeout",
                         "err_param", "err_overrun"};

    ev_t         q[$];
    ev_t         ev;
    logic [4:0]  pulses;
    int          nvec = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          t0;
    vec_t        vt [6];
    pl_t         pz;
    pl_t         pb;

    logic [8:0]  m_px;
    logic [7:0]  m_py;
    logic [15:0] m_cx, m_cy, m_dx, m_dy, m_mi;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic void mdl_reset();
        m_px = 9'd510; m_py = 8'd255;
        m_cx = 16'd0;  m_cy = 16'd0;
        m_dx = 16'd0;  m_dy = 16'd0;
        m_mi = 16'd100;
    endfunction

    function automatic void mdl_load(input pl_t p);
        m_px = {p[0][0], p[1]};
        m_py = p[2];
        m_cx = {p[3], p[4]};
        m_cy = {p[5], p[6]};
        m_dx = {p[7], p[8]};
        m_dy = {p[9], p[10]};
        m_mi = {p[11], p[12]};
    endfunction

    function automatic logic [7:0] xsum(input pl_t p);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < 13; i++) x = x ^ p[i];
        return x;
    endfunction

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind; e.cyc = at;
        e.px = m_px; e.py = m_py;
        e.cx = m_cx; e.cy = m_cy;
        e.dx = m_dx; e.dy = m_dy;
        e.mi = m_mi;
        q.push_back(e);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, " pix_x"}, 32'(pix_x), 32'(m_px));
        chk({tag, " pix_y"}, 32'(pix_y), 32'(m_py));
        chk({tag, " cxs"}, 32'(cxs), 32'(m_cx));
        chk({tag, " cys"}, 32'(cys), 32'(m_cy));
        chk({tag, " dcx"}, 32'(dcx), 32'(m_dx));
        chk({tag, " dcy"}, 32'(dcy), 32'(m_dy));
        chk({tag, " max_iter"}, 32'(max_iter), 32'(m_mi));
    endtask

    // Called at a falling edge; byte is held 4 cycles, gap 4 cycles.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Checksum byte driven at cycle n is accepted at n+3;
    // its result pulse is visible at n+4.
    task automatic send_frame(input pl_t p, input logic [7:0] mask,
                              input int kind);
        send_byte(8'hA5);
        for (int i = 0; i < 13; i++) send_byte(p[i]);
        if (kind == K_ST) mdl_load(p);
        if (kind >= 0) push(kind, cyc + 4);
        send_byte(xsum(p) ^ mask);
    endtask

    task automatic drain();
        ev_t e;
        for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
        while (q.size() != 0) begin
            e = q.pop_front();
            nvec++;
            nfail++;
            $display("FAIL missing_%s: got no pulse, required at cycle %0d",
                     kname[e.kind], e.cyc);
        end
        repeat (10) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pulses = {err_overrun, err_param, err_timeout, err_cksum, start};
            for (int k = 0; k < 5; k++) begin
                if (pulses[k]) begin
                    if (q.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected_%s: got pulse at cycle %0d, required none",
                                 kname[k], cyc);
                    end else begin
                        ev = q.pop_front();
                        chk("pulse kind", 32'(k), 32'(ev.kind));
                        chk({kname[k], " cycle"}, 32'(cyc), 32'(ev.cyc));
                        chk({kname[k], " pix_x"}, 32'(pix_x), 32'(ev.px));
                        chk({kname[k], " pix_y"}, 32'(pix_y), 32'(ev.py));
                        chk({kname[k], " cxs"}, 32'(cxs), 32'(ev.cx));
                        chk({kname[k], " cys"}, 32'(cys), 32'(ev.cy));
                        chk({kname[k], " dcx"}, 32'(dcx), 32'(ev.dx));
                        chk({kname[k], " dcy"}, 32'(dcy), 32'(ev.dy));
                        chk({kname[k], " max_iter"}, 32'(max_iter), 32'(ev.mi));
                    end
                end
            end
        end
    end

    initial begin
        vt[0].name = "bad_cksum";
        vt[0].pl   = '{8'h01, 8'hFD, 8'hFE, 8'hE0, 8'h00, 8'hF0, 8'h00,
                       8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h64};
        vt[0].mask = 8'h01;
        vt[0].kind = K_CK;
        vt[1].name = "good_tp";
        vt[1].pl   = vt[0].pl;
        vt[1].mask = 8'h00;
        vt[1].kind = K_ST;
        vt[2].name = "bad_cksum_hi";
        vt[2].pl   = '{8'h7F, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
                       8'hDE, 8'hF0, 8'h01, 8'h02, 8'h03, 8'h04};
        vt[2].mask = 8'h80;
        vt[2].kind = K_CK;
        vt[3].name = "iter_zero";
        vt[3].pl   = '{8'h00, 8'h40, 8'h30, 8'h10, 8'h00, 8'h20, 8'h00,
                       8'h00, 8'h08, 8'h00, 8'h08, 8'h00, 8'h00};
        vt[3].mask = 8'h00;
        vt[3].kind = K_PA;
        vt[4].name = "a5_inside";
        vt[4].pl   = '{8'hFE, 8'hA5, 8'hA5, 8'hA5, 8'h12, 8'h34, 8'hA5,
                       8'hA5, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hA5};
        vt[4].mask = 8'h00;
        vt[4].kind = K_ST;
        vt[5].name = "hi_bits";
        vt[5].pl   = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        vt[5].mask = 8'h00;
        vt[5].kind = K_ST;

        pz = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
               8'h70, 8'h80, 8'h90, 8'hA0, 8'h00, 8'h00};
        pb = '{8'h00, 8'hC0, 8'h80, 8'h12, 8'h34, 8'h56, 8'h78,
               8'h00, 8'h10, 8'h00, 8'h08, 8'h01, 8'hF4};

        rst         = 1'b1;
        rx_ready    = 1'b0;
        rx_data     = 8'h00;
        engine_busy = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);
        check_outs("reset");
        chk("reset pulses",
            32'({start, err_cksum, err_timeout, err_param, err_overrun}),
            32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].pl, vt[i].mask, vt[i].kind);
            drain();
            check_outs(vt[i].name);
        end

        // Stalled frame: 7 bytes, then silence.
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_byte(vt[1].pl[i]);
        push(K_TO, cyc + 3 + TO);
        send_byte(vt[1].pl[5]);
        drain();
        send_frame(vt[4].pl, 8'h00, K_ST);
        drain();

        // Engine busy with two bytes arriving while pending.
        @(negedge clk);
        engine_busy = 1'b1;
        t0 = cyc;
        send_frame(pb, 8'h00, -1);
        push(K_OV, cyc + 4);
        send_byte(8'h11);
        push(K_OV, cyc + 4);
        send_byte(8'hA5);
        while (cyc < t0 + 500) @(negedge clk);
        mdl_load(pb);
        push(K_ST, cyc + 1);
        engine_busy = 1'b0;
        drain();

        // Garbage, then a long held level carrying the sync byte.
        send_byte(8'h00);
        send_byte(8'h55);
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        repeat (80) @(negedge clk);
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 13; i++) send_byte(pz[i]);
        push(K_PA, cyc + 4);
        send_byte(xsum(pz));
        drain();

        // Reset after 5 bytes of a frame.
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) send_byte(vt[1].pl[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();
        check_outs("mid_reset");
        repeat (5) @(negedge clk);
        send_frame(vt[1].pl, 8'h00, K_ST);
        drain();
        check_outs("final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
